// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for decode, ALU and writeback.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] word_t;

    // r0 reads as zero everywhere; r31 is the jal/jalr link target.
    localparam reg_idx_t ZERO_REG = reg_idx_t'(0);
    localparam reg_idx_t LINK_REG = reg_idx_t'(31);

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, optional same-cycle write forward, r0 forced to zero.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the output is always valid for the presented index.
module regfile_read_port import regfile_pkg::*; #(
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int BYPASS   = 1
) (
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [ADDR_W-1:0] rdIdx,
    input  logic              fwdEn,
    input  logic [ADDR_W-1:0] fwdIdx,
    input  logic [DATA_W-1:0] fwdData,
    output logic [DATA_W-1:0] rdData
);

    // Select stored word, override with the in-flight write when forwarding, then force r0 to zero.
    always_comb begin
        rdData = regs[rdIdx];
        if ((BYPASS != 0) && fwdEn && (fwdIdx == rdIdx)) begin
            rdData = fwdData;
        end
        if (rdIdx == '0) begin
            rdData = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Integer register file: two combinational operand read ports, one write port, one debug read port.
// Latency: reads zero cycles, writes commit on the next rising edge.
// Backpressure: none; every read and write is accepted every cycle.
module reg_file import regfile_pkg::*; #(
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rA,
    input  logic [ADDR_W-1:0] rB,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    input  logic              regWr,
    input  logic [ADDR_W-1:0] rW,
    input  logic [DATA_W-1:0] busW,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wrEn;

    // A write is live only outside reset and never targets r0; this also gates forwarding.
    assign wrEn = regWr && !reset && (rW != '0);

    // Reset clears every entry (dropping any write in that cycle); otherwise commit the write.
    // Entry 0 is only ever loaded with zero, so it collapses to a constant.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[rW] <= busW;
        end
    end

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS)
    ) uPortA (
        .regs   (regs),
        .rdIdx  (rA),
        .fwdEn  (wrEn),
        .fwdIdx (rW),
        .fwdData(busW),
        .rdData (busA)
    );

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS)
    ) uPortB (
        .regs   (regs),
        .rdIdx  (rB),
        .fwdEn  (wrEn),
        .fwdIdx (rW),
        .fwdData(busW),
        .rdData (busB)
    );

    // Debug view shows committed state only, never the in-flight write.
    always_comb begin
        dbgData = regs[dbgAddr];
        if (dbgAddr == '0) begin
            dbgData = '0;
        end
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file that drives the ALU operand buses busA/busB and absorbs the writeback result (ALUout or load data) on busW.
- Sits between decode and execute in the single-cycle datapath.
- 32 x 32-bit registers, two combinational read ports, one synchronous write port, and a side-effect-free debug read port.
- r0 is hardwired to zero.

Parameters:
- DATA_W, 32, register and bus width
- NUM_REGS, 32, number of architectural registers; must be a power of two
- ADDR_W, 5, register index width, log2(NUM_REGS)
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports (write-first); when 0 reads return the pre-write value

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rA  in  ADDR_W  read index for port A
- rB  in  ADDR_W  read index for port B
- busA  out  DATA_W  contents of register rA
- busB  out  DATA_W  contents of register rB
- regWr  in  1  write enable
- rW  in  ADDR_W  write index
- busW  in  DATA_W  write data
- dbgAddr  in  ADDR_W  debug read index
- dbgData  out  DATA_W  contents of register dbgAddr, never bypassed

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: on a rising edge with reset=1, every register is cleared to 0. A write presented in the same cycle is discarded.
- Outputs during reset: busA, busB and dbgData are combinational views of storage, so they read 0 from the first edge after reset rises. Bypass is suppressed while reset=1, so busA/busB never show busW during reset.
- Mid-operation reset: all state, including pending write data, is lost. There is no partial clear.
- Write: at a rising edge with reset=0, regWr=1 and rW!=0, reg[rW] <= busW. Writes to rW=0 are dropped. Write latency is 1 edge.
- Read: busA = (rA==0) ? 0 : reg[rA]. busB likewise. Purely combinational, zero-cycle latency, no clock enable.
- Bypass when BYPASS=1: if regWr=1, reset=0, rW!=0 and rA==rW, then busA = busW in the same cycle. Port B uses the same rule with rB.
- Both ports may bypass simultaneously when rA==rB==rW.
- BYPASS=0: reads show the old value until the write edge.
- r0: reads always return 0 on every port, including dbgData, regardless of writes or bypass. Storage for index 0 may be omitted.
- Simultaneous events: rA==rB with no write returns the same value on both buses. Read and write to the same index in one cycle follow the bypass rule above. There is only one write port, so there are no write-write conflicts.
- Debug port: dbgData = reg[dbgAddr] (0 for index 0). Reflects committed state only, with no bypass. Reading has no side effect.
- Index widths: indices are exactly ADDR_W bits and all 2^ADDR_W values are legal, so there is no out-of-range case.
- No X propagation: all registers are defined after the first reset edge. Before the first reset, contents are unspecified and the bench must not check them.

Decomposition:
- Shared package regfile_pkg:
  - constants REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG=0
  - named indices LINK_REG=31 for jal/jalr writeback selection in the control unit
  - typedef reg_idx_t (ADDR_W bits) and word_t (DATA_W bits), shared with ALU, decode and writeback
- One sub-module, regfile_read_port: storage-array mux plus zero-force plus optional bypass compare. Instantiated twice, for A and B.
- The debug port is a plain mux and is not an instance.

Test Plan:
- Reset clear: preload r5=0xDEADBEEF, assert reset for 1 edge, set rA=5 -> busA=0x00000000 after the edge. A write of r6=0x1 in the reset cycle is dropped, so a later read of r6 = 0.
- Basic write/read: regWr=1, rW=7, busW=0x12345678 at edge N; rA=7, rB=7 at N+1 -> busA=busB=0x12345678; dbgAddr=7 -> dbgData=0x12345678.
- r0 immutability: regWr=1, rW=0, busW=0xFFFFFFFF, rA=0 -> busA=0 in the same cycle (no bypass) and after the edge; dbgData at index 0 = 0.
- Bypass, BYPASS=1: r3 holds 0x11; in one cycle regWr=1, rW=3, busW=0x22, rA=3, rB=3 -> busA=busB=0x22 combinationally, while dbgData at index 3 = 0x11 until the edge, then 0x22.
- No bypass, BYPASS=0: same stimulus -> busA=busB=0x11 before the edge, 0x22 after.
- Back-to-back and full sweep: write r1..r31 with value i*0x01010101 on consecutive edges, then read all pairs (rA=i, rB=31-i) -> both buses match the expected values. Finish with a random write/read stream against a scoreboard model, 10k cycles.
